aes_round_seq: RTL and testbench

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_round_seq.sv | 156 +++++++++++++++
 tb/tb_aes_round_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// Round sequencer for an external AES T-table round block: walks the round keys through a
// synchronous key RAM, feeds each round to the block and captures its result.
module aes_round_seq #(
    parameter int unsigned NR      = 10,
    parameter int unsigned BLK_LAT = 4
) (
    input  logic         bram_clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [127:0] text_in,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic [127:0] blk_din,
    output logic [127:0] blk_key,
    output logic         E_D,
    output logic         T_S,
    input  logic [127:0] blk_dout,
    output logic         busy,
    output logic         done,
    output logic [127:0] text_out
);

    localparam logic [3:0]  NR_L = 4'(NR);
    localparam int unsigned CW   = (BLK_LAT > 1) ? $clog2(BLK_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(BLK_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StKey0,
        StAdd0,
        StWait,
        StCapt,
        StDone
    } state_e;

    state_e          st_q, st_d;
    logic [3:0]      round_q, round_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      rk_addr_q, rk_addr_d;
    logic            mode_q, mode_d;
    logic [127:0]    state_q, state_d;
    logic [127:0]    text_out_q, text_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            t_s_q, t_s_d;
    logic            e_d_q, e_d_d;

    // Decrypt walks the key RAM backwards; it already holds the inverse-cipher keys.
    function automatic logic [3:0] key_idx(input logic m, input logic [3:0] i);
        return m ? (NR_L - i) : i;
    endfunction

    always_comb begin
        st_d       = st_q;
        round_d    = round_q;
        cnt_d      = cnt_q;
        rk_addr_d  = rk_addr_q;
        mode_d     = mode_q;
        state_d    = state_q;
        text_out_d = text_out_q;

        unique case (st_q)
            StIdle: begin
                if (start) begin
                    state_d   = text_in;
                    mode_d    = mode;
                    rk_addr_d = key_idx(mode, 4'd0);
                    round_d   = 4'd0;
                    st_d      = StKey0;
                end
            end
            StKey0: begin
                rk_addr_d = key_idx(mode_q, 4'd1);
                st_d      = StAdd0;
            end
            StAdd0: begin
                state_d = state_q ^ rk_data;
                round_d = 4'd1;
                cnt_d   = WAIT_LAST;
                st_d    = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    st_d = StCapt;
                    // Next key is requested on entry to CAPT so it is in rk_data for the next WAIT.
                    if (round_q != NR_L) begin
                        rk_addr_d = key_idx(mode_q, 4'(round_q + 4'd1));
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCapt: begin
                state_d = blk_dout;
                if (round_q == NR_L) begin
                    text_out_d = blk_dout;
                    st_d       = StDone;
                end else begin
                    round_d = 4'(round_q + 4'd1);
                    cnt_d   = WAIT_LAST;
                    st_d    = StWait;
                end
            end
            StDone: begin
                st_d = StIdle;
            end
            default: begin
                st_d = StIdle;
            end
        endcase

        busy_d = (st_d != StIdle);
        done_d = (st_d == StDone);
        t_s_d  = ((st_d == StWait) || (st_d == StCapt)) && (round_d == NR_L);
        e_d_d  = mode_d;
    end

    always_ff @(posedge bram_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= StIdle;
            round_q    <= 4'd0;
            cnt_q      <= '0;
            rk_addr_q  <= 4'd0;
            mode_q     <= 1'b0;
            state_q    <= '0;
            text_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            t_s_q      <= 1'b0;
            e_d_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            round_q    <= round_d;
            cnt_q      <= cnt_d;
            rk_addr_q  <= rk_addr_d;
            mode_q     <= mode_d;
            state_q    <= state_d;
            text_out_q <= text_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            t_s_q      <= t_s_d;
            e_d_q      <= e_d_d;
        end
    end

    assign rk_addr  = rk_addr_q;
    assign blk_din  = state_q;
    assign blk_key  = ((st_q == StWait) || (st_q == StCapt)) ? rk_data : '0;
    assign E_D      = e_d_q;
    assign T_S      = t_s_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq: emulates the key RAM and a latency-BLK_LAT round block, and checks
// every cycle against a cycle-count model plus a textbook AES-128 reference.
module tb_aes_round_seq;

    localparam int unsigned NR  = 10;
    localparam int unsigned L   = 4;
    localparam int          LAT = 2 + NR * (L + 1);

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         bram_clk, rst_n, start, mode;
    logic [127:0] text_in, rk_data, blk_din, blk_key, blk_dout, text_out;
    logic [3:0]   rk_addr;
    logic         E_D, T_S, busy, done;

    aes_round_seq #(.NR(NR), .BLK_LAT(L)) dut (
        .bram_clk(bram_clk), .rst_n(rst_n), .start(start), .mode(mode), .text_in(text_in),
        .rk_addr(rk_addr), .rk_data(rk_data), .blk_din(blk_din), .blk_key(blk_key),
        .E_D(E_D), .T_S(T_S), .blk_dout(blk_dout), .busy(busy), .done(done),
        .text_out(text_out)
    );

    initial bram_clk = 1'b0;
    always #5 bram_clk = ~bram_clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- AES arithmetic ----------------
    logic [7:0] sbox [256];
    logic [7:0] isbox[256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] getb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_b(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv ? isbox[getb(x, i)] : sbox[getb(x, i)];
        return y;
    endfunction

    function automatic logic [127:0] shift_r(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        int src;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                y[127-8*(r+4*c) -: 8] = getb(x, r + 4 * src);
            end
        return y;
    endfunction

    function automatic logic [127:0] mix_c(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        logic [7:0]   m[4];
        logic [7:0]   acc;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - r + 4) % 4], getb(x, j + 4 * c));
                y[127-8*(r+4*c) -: 8] = acc;
            end
        return y;
    endfunction

    function automatic logic [127:0] rkey(input logic [127:0] key, input int n);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] ^= rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Textbook cipher and inverse cipher (not the equivalent-inverse form the round block uses).
    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        s = pt ^ rkey(key, 0);
        for (int r = 1; r < NR; r++) s = mix_c(shift_r(sub_b(s, 0), 0), 0) ^ rkey(key, r);
        return shift_r(sub_b(s, 0), 0) ^ rkey(key, NR);
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
        logic [127:0] s;
        s = ct ^ rkey(key, NR);
        for (int r = NR - 1; r >= 1; r--) s = mix_c(sub_b(shift_r(s, 1), 1) ^ rkey(key, r), 1);
        return sub_b(shift_r(s, 1), 1) ^ rkey(key, 0);
    endfunction

    function automatic logic [127:0] round_blk(input logic [127:0] din, input logic [127:0] k,
                                               input logic ed, input logic ts);
        logic [127:0] s;
        s = shift_r(sub_b(din, ed), ed);
        if (!ts) s = mix_c(s, ed);
        return s ^ k;
    endfunction

    task automatic init_tables();
        logic [7:0] inv, s, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            s = inv; b = inv;
            for (int k = 0; k < 4; k++) begin
                b = {b[6:0], b[7]};
                s ^= b;
            end
            s ^= 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    // ---------------- environment: key RAM and round block ----------------
    logic [127:0] ram [16];
    logic [127:0] pipe[L];
    logic [127:0] cur_key;

    always @(posedge bram_clk) rk_data <= ram[rk_addr];

    always @(posedge bram_clk) begin
        pipe[0] <= round_blk(blk_din, blk_key, E_D, T_S);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign blk_dout = pipe[L-1];

    task automatic load_keys(input logic [127:0] key, input logic m);
        logic [127:0] k;
        for (int i = 0; i <= NR; i++) begin
            k = rkey(key, i);
            ram[i] = (m && i != 0 && i != NR) ? mix_c(k, 1) : k;
        end
    endtask

    // ---------------- reference model ----------------
    bit           active;
    int           e;
    logic         m_mode;
    logic [127:0] exp_res, exp_out;

    always @(posedge bram_clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            e       <= 0;
            exp_out <= '0;
        end else if (active) begin
            if (e == LAT) active <= 1'b0;
            else begin
                e <= e + 1;
                if (e == LAT - 1) exp_out <= exp_res;
            end
        end else if (start) begin
            active  <= 1'b1;
            e       <= 0;
            m_mode  <= mode;
            exp_res <= mode ? aes_dec(text_in, cur_key) : aes_enc(text_in, cur_key);
        end
    end

    function automatic logic [3:0] kidx(input int i, input logic m);
        return m ? 4'(NR - i) : 4'(i);
    endfunction

    function automatic logic [3:0] exp_addr(input int ee, input logic m);
        int k;
        if (ee == 0) return kidx(0, m);
        k = 0;
        for (int r = 1; r < NR; r++) if (1 + r * (L + 1) <= ee) k++;
        return kidx(1 + k, m);
    endfunction

    logic [127:0] prev_din;
    int           done_cnt = 0;
    int           rnd, pos;

    always @(negedge bram_clk) begin
        if (rst_n) begin
            chk("busy", busy, active);
            chk("done", done, active && e == LAT);
            chk("T_S", T_S, active && e >= 2 + (NR - 1) * (L + 1) && e <= 1 + NR * (L + 1));
            chk("text_out", text_out, exp_out);
            if (active) begin
                chk("E_D", E_D, m_mode);
                chk("rk_addr", rk_addr, exp_addr(e, m_mode));
                if (e >= 2 && e < LAT) begin
                    rnd = (e - 2) / (L + 1) + 1;
                    pos = (e - 2) % (L + 1);
                    chk("blk_key", blk_key, ram[kidx(rnd, m_mode)]);
                    if (pos > 0) chk("blk_din_stable", blk_din, prev_din);
                end
            end
            if (done) done_cnt <= done_cnt + 1;
        end
        prev_din <= blk_din;
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic [127:0] key, input logic m, input logic [127:0] txt,
                          input bit noisy);
        int d0;
        load_keys(key, m);
        cur_key = key;
        @(negedge bram_clk);
        start = 1'b1; mode = m; text_in = txt;
        @(negedge bram_clk);
        start = 1'b0;
        d0 = done_cnt;
        for (int c = 0; c <= LAT; c++) begin
            if (noisy) begin
                start   = (c == 5 || c == 30 || c == LAT);
                text_in = {$urandom, $urandom, $urandom, $urandom};
                mode    = 1'($urandom);
            end
            @(negedge bram_clk);
        end
        start = 1'b0;
        @(negedge bram_clk);
        chk("done_count", 128'(done_cnt - d0), 128'd1);
    endtask

    task automatic check_all_zero();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_T_S", T_S, 0);
        chk("rst_E_D", E_D, 0);
        chk("rst_rk_addr", rk_addr, 0);
        chk("rst_blk_din", blk_din, 0);
        chk("rst_blk_key", blk_key, 0);
        chk("rst_text_out", text_out, 0);
    endtask

    initial begin
        int d0;
        logic [127:0] k, t;
        init_tables();
        for (int i = 0; i < 16; i++) ram[i] = '0;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; text_in = '0; cur_key = '0;
        repeat (3) @(negedge bram_clk);
        check_all_zero();

        // Pin the reference model to the published vector.
        chk("ref_enc_fips", aes_enc(FIPS_PT, FIPS_KEY), FIPS_CT);
        chk("ref_dec_fips", aes_dec(FIPS_CT, FIPS_KEY), FIPS_PT);
        chk("ref_sbox", {sbox[0], sbox[1], isbox[8'h63]}, 24'h637c00);

        rst_n = 1'b1;
        run_op(FIPS_KEY, 1'b0, FIPS_PT, 1'b1);
        chk("fips_enc_out", text_out, FIPS_CT);
        repeat (3) @(negedge bram_clk);
        chk("fips_enc_hold", text_out, FIPS_CT);

        run_op(FIPS_KEY, 1'b1, FIPS_CT, 1'b0);
        chk("fips_dec_out", text_out, FIPS_PT);

        // Abort mid-operation, then run a clean one.
        load_keys(FIPS_KEY, 1'b0);
        cur_key = FIPS_KEY;
        @(negedge bram_clk);
        start = 1'b1; mode = 1'b0; text_in = FIPS_PT;
        @(negedge bram_clk);
        start = 1'b0;
        d0 = done_cnt;
        repeat (20) @(negedge bram_clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero();
        repeat (LAT) @(negedge bram_clk);
        chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
        rst_n = 1'b1;
        run_op(FIPS_KEY, 1'b0, FIPS_PT, 1'b0);
        chk("after_rst_out", text_out, FIPS_CT);

        // Back-to-back with start held high.
        k = {$urandom, $urandom, $urandom, $urandom};
        t = {$urandom, $urandom, $urandom, $urandom};
        load_keys(k, 1'b0);
        cur_key = k;
        @(negedge bram_clk);
        start = 1'b1; mode = 1'b0; text_in = FIPS_PT;
        @(negedge bram_clk);
        d0 = done_cnt;
        text_in = t;
        repeat (LAT + 2) @(negedge bram_clk);
        start = 1'b0;
        repeat (LAT + 2) @(negedge bram_clk);
        chk("b2b_done_count", 128'(done_cnt - d0), 128'd2);
        chk("b2b_second_out", text_out, aes_enc(t, k));

        for (int n = 0; n < 6; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            t = {$urandom, $urandom, $urandom, $urandom};
            run_op(k, 1'($urandom), t, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
